// File: rtl/johnson_phase_decoder_8_bit_if.sv
// Signal bundle between the Johnson counter and the phase decoder, plus the decoded phase outputs.
// Optional port Phase_One_Hot_Out exists only when JOHNSON_PHASE_ONE_HOT_EN is defined.
interface johnson_phase_decoder_8_bit_if #(
    parameter int CYCLE_WIDTH = 8
);
    logic                   Enable_In;
    logic                   Clear_In;
    logic                   Counter_Running_Flag_In;
    logic [7:0]             Counter_Count_In;

    // Phase_Valid_Out qualifies Phase_Index_Out on every cycle it is high; there is no
    // ready/backpressure, so a consumer must take the index whenever it is valid.
    logic [3:0]             Phase_Index_Out;
    logic                   Phase_Valid_Out;
    logic                   Phase_Strobe_Out;
    logic                   Cycle_Wrap_Out;
    logic [CYCLE_WIDTH-1:0] Cycle_Count_Out;
    logic                   Sequence_Error_Out;
    logic [1:0]             Decoder_State_Out;
`ifdef JOHNSON_PHASE_ONE_HOT_EN
    logic [15:0]            Phase_One_Hot_Out;

    modport master (
        output Enable_In, Clear_In, Counter_Running_Flag_In, Counter_Count_In,
        input  Phase_Index_Out, Phase_Valid_Out, Phase_Strobe_Out, Cycle_Wrap_Out,
               Cycle_Count_Out, Sequence_Error_Out, Decoder_State_Out, Phase_One_Hot_Out
    );

    modport slave (
        input  Enable_In, Clear_In, Counter_Running_Flag_In, Counter_Count_In,
        output Phase_Index_Out, Phase_Valid_Out, Phase_Strobe_Out, Cycle_Wrap_Out,
               Cycle_Count_Out, Sequence_Error_Out, Decoder_State_Out, Phase_One_Hot_Out
    );
`else
    modport master (
        output Enable_In, Clear_In, Counter_Running_Flag_In, Counter_Count_In,
        input  Phase_Index_Out, Phase_Valid_Out, Phase_Strobe_Out, Cycle_Wrap_Out,
               Cycle_Count_Out, Sequence_Error_Out, Decoder_State_Out
    );

    modport slave (
        input  Enable_In, Clear_In, Counter_Running_Flag_In, Counter_Count_In,
        output Phase_Index_Out, Phase_Valid_Out, Phase_Strobe_Out, Cycle_Wrap_Out,
               Cycle_Count_Out, Sequence_Error_Out, Decoder_State_Out
    );
`endif
endinterface

// File: rtl/johnson_phase_decoder_8_bit.sv
// Decodes an 8-bit Johnson count into a 4-bit phase, tracks single-step advances and laps,
// and latches a sticky error on illegal codes or skipped steps. Option: JOHNSON_PHASE_ONE_HOT_EN.
module johnson_phase_decoder_8_bit #(
    parameter int CYCLE_WIDTH = 8
) (
    input  logic                          Clk_In,
    input  logic                          Reset_N_In,
    johnson_phase_decoder_8_bit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TRACK  = 2'b01,
        ERROR  = 2'b10,
        UNUSED = 2'b11
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_index;
    logic                   r_valid;
    logic                   r_strobe;
    logic                   r_wrap;
    logic [CYCLE_WIDTH-1:0] r_cycle_count;
    logic                   r_error;

    logic [7:0]             w_norm;
    logic [7:0]             w_norm_inc;
    logic [2:0]             w_ones;
    logic                   w_legal;
    logic [3:0]             w_new_index;
    logic [3:0]             w_delta;
    logic                   w_running;

    function automatic logic [2:0] f_ones(input logic [6:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 7; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Folding codes with the MSB set by inversion turns both legal families into a
    // thermometer filled from the LSB; the MSB then selects the upper half of the phase range.
    assign w_norm      = bus.Counter_Count_In[7] ? ~bus.Counter_Count_In : bus.Counter_Count_In;
    assign w_norm_inc  = w_norm + 8'd1;
    assign w_legal     = ((w_norm & w_norm_inc) == 8'd0);
    assign w_ones      = f_ones(w_norm[6:0]);
    assign w_new_index = {bus.Counter_Count_In[7], w_ones};
    assign w_delta     = w_new_index - r_index;
    assign w_running   = bus.Counter_Running_Flag_In;

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_state       <= IDLE;
            r_index       <= 4'd0;
            r_valid       <= 1'b0;
            r_strobe      <= 1'b0;
            r_wrap        <= 1'b0;
            r_cycle_count <= '0;
            r_error       <= 1'b0;
        end else if (bus.Clear_In) begin
            // An illegal code during clear only drops valid; IDLE escalates it next cycle.
            r_state       <= IDLE;
            r_strobe      <= 1'b0;
            r_wrap        <= 1'b0;
            r_cycle_count <= '0;
            r_error       <= 1'b0;
            if (w_legal) begin
                r_index <= w_new_index;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end else begin
            r_strobe <= 1'b0;
            r_wrap   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_index <= w_new_index;
                        r_valid <= 1'b1;
                        r_state <= w_running ? TRACK : IDLE;
                    end else begin
                        r_state <= ERROR;
                        r_error <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                TRACK: begin
                    if (w_legal && (w_delta == 4'd0)) begin
                        r_state <= w_running ? TRACK : IDLE;
                    end else if (w_legal && (w_delta == 4'd1)) begin
                        r_index  <= w_new_index;
                        r_strobe <= 1'b1;
                        r_state  <= w_running ? TRACK : IDLE;
                        if (r_index == 4'd15) begin
                            r_wrap        <= 1'b1;
                            r_cycle_count <= r_cycle_count + 1'b1;
                        end
                    end else begin
                        r_state <= ERROR;
                        r_error <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                ERROR: begin
                    r_valid <= 1'b0;
                    r_error <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_error <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Phase_Index_Out    = bus.Enable_In ? r_index       : 'z;
    assign bus.Phase_Valid_Out    = bus.Enable_In ? r_valid       : 1'bz;
    assign bus.Phase_Strobe_Out   = bus.Enable_In ? r_strobe      : 1'bz;
    assign bus.Cycle_Wrap_Out     = bus.Enable_In ? r_wrap        : 1'bz;
    assign bus.Cycle_Count_Out    = bus.Enable_In ? r_cycle_count : 'z;
    assign bus.Sequence_Error_Out = bus.Enable_In ? r_error       : 1'bz;
    assign bus.Decoder_State_Out  = bus.Enable_In ? r_state       : 'z;

`ifdef JOHNSON_PHASE_ONE_HOT_EN
    logic        w_oh_load;
    logic        w_oh_keep;
    logic [15:0] r_one_hot;

    // Mirrors the index/valid decisions of the FSM so the one-hot lands on the same edge.
    assign w_oh_load = bus.Clear_In ? w_legal
                     : (((r_state == IDLE) && w_legal) ||
                        ((r_state == TRACK) && w_legal && (w_delta == 4'd1)));
    assign w_oh_keep = !bus.Clear_In && (r_state == TRACK) && w_legal && (w_delta == 4'd0);

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_one_hot <= 16'd0;
        end else if (w_oh_load) begin
            r_one_hot <= 16'd1 << w_new_index;
        end else if (!w_oh_keep) begin
            r_one_hot <= 16'd0;
        end
    end

    assign bus.Phase_One_Hot_Out = bus.Enable_In ? r_one_hot : 'z;
`endif

endmodule
